// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings and the DMA master FSM state type.
//   HTRANS_*  : transfer type codes (only IDLE and NONSEQ are ever used)
//   HSIZE_WORD, HBURST_SINGLE, HPROT_DATA : fixed attributes of every transfer
//   dma_state_e : copy engine states
//   word_align(): clears byte-offset bits of a byte address
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_DONE = 3'd5
  } dma_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ahbl_dma_master.sv
// ahbl_dma_master: single-channel AHB-Lite memory-to-memory copy engine.
// Copies len 32-bit words from src_addr to dst_addr, one SINGLE read followed
// by one SINGLE write per word. An error response aborts the copy.
// Ports:
//   HCLK, HRESETn            : clock, asynchronous active-low reset
//   start, src_addr, dst_addr, len : copy request (sampled only while idle)
//   busy, done, err          : status (done is a one-cycle pulse, err sticky)
//   HADDR..HWDATA            : AHB-Lite master outputs
//   HRDATA, HREADY, HRESP    : AHB-Lite master inputs
// Optional feature macro AHBL_DMA_IRQ_EN adds irq (out) and irq_clr (in).
// All bus/status outputs are driven from registers loaded with next-state values.
module ahbl_dma_master
  import ahbl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
`ifdef AHBL_DMA_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  dma_state_e       state_r, state_s;
  logic [31:0]      src_r, src_s;
  logic [31:0]      dst_r, dst_s;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic [31:0]      buf_r, buf_s;
  logic             err_r, err_s;
  logic [31:0]      haddr_r, haddr_s;
  logic [1:0]       htrans_r, htrans_s;
  logic             hwrite_r, hwrite_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HADDR     = haddr_r;
  assign HTRANS    = htrans_r;
  assign HWRITE    = hwrite_r;
  // The read buffer is held unchanged across the whole write data phase.
  assign HWDATA    = buf_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    cnt_s   = cnt_r;
    buf_s   = buf_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          err_s = 1'b0;
          if (len != LEN_W'(0)) begin
            src_s   = word_align(src_addr);
            dst_s   = word_align(dst_addr);
            cnt_s   = len;
            state_s = ST_RD_A;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (HREADY) state_s = ST_RD_D;
        else        state_s = ST_RD_A;
      end
      ST_RD_D: begin
        // An error response aborts regardless of HREADY.
        if (HRESP) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if (HREADY) begin
          buf_s   = HRDATA;
          state_s = ST_WR_A;
        end else begin
          state_s = ST_RD_D;
        end
      end
      ST_WR_A: begin
        if (HREADY) state_s = ST_WR_D;
        else        state_s = ST_WR_A;
      end
      ST_WR_D: begin
        if (HRESP) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if (HREADY) begin
          src_s = src_r + 32'd4;
          dst_s = dst_r + 32'd4;
          cnt_s = cnt_r - LEN_W'(1);
          if (cnt_r == LEN_W'(1)) state_s = ST_DONE;
          else                    state_s = ST_RD_A;
        end else begin
          state_s = ST_WR_D;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    // Bus outputs follow the state being entered so they appear registered.
    if (state_s == ST_RD_A) begin
      htrans_s = HTRANS_NONSEQ;
      haddr_s  = src_s;
    end else if (state_s == ST_WR_A) begin
      htrans_s = HTRANS_NONSEQ;
      haddr_s  = dst_s;
    end else begin
      htrans_s = HTRANS_IDLE;
      haddr_s  = haddr_r;
    end
    hwrite_s = (state_s == ST_WR_A) || (state_s == ST_WR_D);
    busy_s   = (state_s == ST_RD_A) || (state_s == ST_RD_D) ||
               (state_s == ST_WR_A) || (state_s == ST_WR_D);
    done_s   = (state_s == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r  <= ST_IDLE;
      src_r    <= 32'd0;
      dst_r    <= 32'd0;
      cnt_r    <= LEN_W'(0);
      buf_r    <= 32'd0;
      err_r    <= 1'b0;
      haddr_r  <= 32'd0;
      htrans_r <= HTRANS_IDLE;
      hwrite_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      src_r    <= src_s;
      dst_r    <= dst_s;
      cnt_r    <= cnt_s;
      buf_r    <= buf_s;
      err_r    <= err_s;
      haddr_r  <= haddr_s;
      htrans_r <= htrans_s;
      hwrite_r <= hwrite_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

`ifdef AHBL_DMA_IRQ_EN
  logic irq_r;
  assign irq = irq_r;

  // Interrupt latch: completion sets it, irq_clr clears it, set has priority
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_r <= 1'b0;
    end else if (done_s) begin
      irq_r <= 1'b1;
    end else if (irq_clr) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_r;
    end
  end
`endif

endmodule

// File: tb/tb_ahbl_dma_master.sv
// tb_ahbl_dma_master: directed self-checking bench for ahbl_dma_master.
// A zero-wait/wait-state AHB slave model runs inside the stimulus process;
// expected writes are queued when a copy is launched and popped on each
// completed write data phase. Define AHBL_DMA_IRQ_EN to also exercise irq.
module tb_ahbl_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK, HWRITE;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;
`ifdef AHBL_DMA_IRQ_EN
  logic        irq, irq_clr;
`endif

  ahbl_dma_master #(.LEN_W(16)) dut (
`ifdef AHBL_DMA_IRQ_EN
    .irq(irq), .irq_clr(irq_clr),
`endif
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt, done_cnt, nonseq_cnt;
  logic [63:0] sb[$];
  logic        dp_valid, dp_write, dp_err;
  logic [31:0] dp_addr;
  int          wait_left, wr_waits, err_rd_idx, rd_idx;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT at negedge, then play the slave for this cycle.
  task automatic tick();
    logic [63:0] e;
    @(negedge HCLK);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    check("htrans_legal", {31'd0, HTRANS[0]}, 32'd0);
    if (HTRANS == 2'b10) begin
      nonseq_cnt++;
      check("haddr_align", {30'd0, HADDR[1:0]}, 32'd0);
    end
    if (!HRESETn) begin
      dp_valid = 1'b0; wait_left = 0; HREADY = 1'b1; HRESP = 1'b0;
    end else if (dp_valid && wait_left > 0) begin
      HREADY = 1'b0; HRESP = 1'b0; wait_left--;
      if (dp_write && sb.size() > 0) begin
        e = sb[0];
        check("wait_haddr", HADDR, e[63:32]);
        check("wait_hwdata", HWDATA, e[31:0]);
      end
    end else begin
      HREADY = 1'b1;
      HRESP  = dp_valid && dp_err;
      HRDATA = (dp_valid && !dp_write) ? pat(dp_addr) : 32'd0;
      if (dp_valid && dp_write) begin
        if (sb.size() == 0) begin
          check("unexpected_write", HADDR, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", dp_addr, e[63:32]);
          check("wr_data", HWDATA, e[31:0]);
        end
      end
      if (dp_valid && !dp_write) rd_idx++;
      dp_valid  = (HTRANS == 2'b10);
      dp_write  = HWRITE;
      dp_addr   = HADDR;
      wait_left = HWRITE ? wr_waits : 0;
      dp_err    = dp_valid && !HWRITE && (rd_idx == err_rd_idx);
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int waits, input int eidx, input int exp_busy,
                          input logic exp_err, input bit poke);
    logic [31:0] sa, da;
    int exp_ns;
    wr_waits = waits; err_rd_idx = eidx; rd_idx = 0;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int k = 0; k < n; k++)
      if (eidx < 0 || k < eidx) sb.push_back({da + 32'(4 * k), pat(sa + 32'(4 * k))});
    exp_ns = (n == 0) ? 0 : ((eidx < 0) ? 2 * n : 2 * eidx + 1);
    src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1;
    busy_cnt = 0; done_cnt = 0; nonseq_cnt = 0;
    tick();
    start = 1'b0;
    if (n > 0) check("err_cleared", {31'd0, err}, 32'd0);
    for (int i = 0; i < 300 && !done; i++) begin
      if (poke && i == 3) begin start = 1'b1; len = 16'd9; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("err_at_done", {31'd0, err}, {31'd0, exp_err});
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_count", done_cnt, 32'd1);
    check("err_sticky", {31'd0, err}, {31'd0, exp_err});
    check("nonseq_count", nonseq_cnt, exp_ns);
    check("sb_empty", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    dp_valid = 1'b0; dp_write = 1'b0; dp_err = 1'b0; dp_addr = 32'd0;
    wait_left = 0; wr_waits = 0; err_rd_idx = -1; rd_idx = 0;
    busy_cnt = 0; done_cnt = 0; nonseq_cnt = 0;
`ifdef AHBL_DMA_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("hsize", {29'd0, HSIZE}, 32'd2);
    check("hburst", {29'd0, HBURST}, 32'd0);
    check("hprot", {28'd0, HPROT}, 32'd3);
    check("hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    HRESETn = 1'b1;
    nonseq_cnt = 0;
    repeat (3) tick();
    check("idle_after_reset", nonseq_cnt, 32'd0);

    // basic copy, zero-wait, with an ignored start while busy
    run_copy(32'h0000_0100, 32'h2000_0000, 3, 0, -1, 12, 1'b0, 1'b1);
    // same copy with two wait states on every write
    run_copy(32'h0000_0100, 32'h2000_0000, 3, 2, -1, 18, 1'b0, 1'b0);
    // zero-length request
    run_copy(32'h0000_0200, 32'h3000_0000, 0, 0, -1, 0, 1'b0, 1'b0);
    // error on the second read
    run_copy(32'h0000_0100, 32'h2000_0000, 3, 0, 1, 6, 1'b1, 1'b0);
    // next start clears err; unaligned addresses wrapping past 2^32
    run_copy(32'hFFFF_FFFB, 32'hFFFF_FFFE, 3, 1, -1, 15, 1'b0, 1'b0);

    // asynchronous reset during a write data phase
    src_addr = 32'h0000_0040; dst_addr = 32'h0000_0080; len = 16'd2; start = 1'b1;
    wr_waits = 0; err_rd_idx = -1; rd_idx = 0;
    sb.push_back({32'h0000_0080, pat(32'h0000_0040)});
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy && HWRITE && HTRANS == 2'b00) break;
      tick();
    end
    check("reached_wr_d", {31'd0, busy && HWRITE && (HTRANS == 2'b00)}, 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("mid_rst_haddr", HADDR, 32'd0);
    check("mid_rst_hwdata", HWDATA, 32'd0);
    check("mid_rst_hwrite", {31'd0, HWRITE}, 32'd0);
    sb.delete();
    dp_valid = 1'b0; wait_left = 0;
    tick(); tick();
    HRESETn = 1'b1;
    busy_cnt = 0; nonseq_cnt = 0;
    repeat (5) tick();
    check("post_rst_idle", nonseq_cnt, 32'd0);
    check("post_rst_busy", busy_cnt, 32'd0);
    run_copy(32'h0000_0040, 32'h0000_0080, 2, 0, -1, 8, 1'b0, 1'b0);

`ifdef AHBL_DMA_IRQ_EN
    check("irq_after_done", {31'd0, irq}, 32'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_cleared", {31'd0, irq}, 32'd0);
    src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0; start = 1'b1; irq_clr = 1'b1;
    tick();
    start = 1'b0; irq_clr = 1'b0;
    check("irq_done_same", {31'd0, done}, 32'd1);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahbl_dma_master.md
AHBL_DMA_MASTER -- requirements
Module: ahbl_dma_master

Interface
REQ-001 Parameter LEN_W, default 16, width of the word-count input.
REQ-002 Clock and reset are fixed: one clock, HCLK; reset HRESETn, asynchronous, active-low.
REQ-003 HCLK  in  1  AHB clock; all logic on rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  launch a copy; sampled only in IDLE.
REQ-006 src_addr  in  32  source byte address; bits [1:0] ignored.
REQ-007 dst_addr  in  32  destination byte address; bits [1:0] ignored.
REQ-008 len  in  LEN_W  number of 32-bit words to copy.
REQ-009 busy  out  1  high from the cycle after start is accepted until DONE.
REQ-010 done  out  1  one-cycle pulse at completion or abort.
REQ-011 err  out  1  sticky HRESP error flag; cleared by the next accepted start.
REQ-012 HADDR, HTRANS[1:0], HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK, HWRITE, HWDATA[31:0]  out  AHB-Lite master outputs.
REQ-013 HRDATA[31:0], HREADY, HRESP  in  AHB-Lite master inputs from the interconnect.

Function
REQ-014 Constant outputs: HSIZE=3'b010, HBURST=3'b000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
REQ-015 HTRANS shall be only NONSEQ (2'b10) or IDLE (2'b00); BUSY and SEQ are never driven.
REQ-016 FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, DONE.
REQ-017 IDLE: start=1 and len!=0 -> latch src, dst and len, clear err, go to RD_A.
REQ-018 IDLE: start=1 and len=0 -> go to DONE directly; no bus transfer occurs.
REQ-019 RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=src; advance to RD_D on the first cycle with HREADY=1.
REQ-020 RD_D: drive HTRANS=IDLE; on HREADY=1, capture HRDATA into a 32-bit buffer and go to WR_A.
REQ-021 WR_A: drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst; advance to WR_D on HREADY=1.
REQ-022 WR_D: drive HWDATA=buffer stable until HREADY=1; then src+=4, dst+=4, count-=1.
REQ-023 WR_D exit: count=0 after the decrement -> DONE; otherwise -> RD_A.
REQ-024 Each word takes 4 cycles with zero-wait slaves; every slave wait state adds exactly one cycle.
REQ-025 DONE lasts one cycle: done=1, busy=0, then return to IDLE.
REQ-026 HRESP=1 in any data phase: set err, drive HTRANS=IDLE, go to DONE; no further transfers are issued.
REQ-027 start while busy is ignored.
REQ-028 Addresses wrap modulo 2^32.
REQ-029 HADDR[1:0] is always 2'b00.

Reset
REQ-030 On HRESETn=0 (asynchronous, including mid-transfer): state=IDLE; busy, done, err =0; HTRANS=IDLE; HADDR, HWDATA, HWRITE, buffer, count =0.
REQ-031 The first transfer after reset release requires a new start.

Configuration
REQ-032 AHBL_DMA_IRQ_EN defined: add ports irq (out 1) and irq_clr (in 1).
REQ-033 irq sets on done and clears on irq_clr; if both occur in the same cycle, set wins.
REQ-034 AHBL_DMA_IRQ_EN undefined: irq and irq_clr ports are absent; all other behaviour is identical.

Structure
REQ-035 Shared package ahbl_pkg holds the HTRANS, HSIZE, HBURST and HPROT encodings and the FSM state typedef.
REQ-036 No sub-module is required; single module only.

Verification
REQ-037 src=0x0000_0100, dst=0x2000_0000, len=3, zero-wait RAM -> 3 words copied, busy for 12 cycles, single done pulse, err=0.
REQ-038 Same copy with a slave inserting 2 wait states on each write -> 18 busy cycles; HWDATA and HADDR stable during waits.
REQ-039 len=0 -> done pulse 1 cycle after start; HTRANS stays IDLE throughout.
REQ-040 HRESP=1 on the 2nd read -> err=1, done pulse, no write issued for word 2; next start clears err.
REQ-041 HRESETn asserted during WR_D -> outputs reach their reset values immediately; bus stays IDLE until the next start.
REQ-042 With AHBL_DMA_IRQ_EN defined: irq rises with done; irq_clr and done in the same cycle -> irq stays 1.
